// File: rtl/adder_op_driver_pkg.sv
// Shared encodings for the 4-bit adder pin protocol and its initiator-side driver.
package adder_op_driver_pkg;

  localparam int unsigned OPERAND_W = 4;

  // Debug state reported by the adder core on its state[1:0] pins.
  typedef enum logic [1:0] {
    AdderIdle    = 2'b00,
    AdderLoadedA = 2'b01,
    AdderResult  = 2'b10
  } adder_state_e;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFlushB   = 3'd1,
    StFlushGap = 3'd2,
    StDrvA     = 3'd3,
    StDrvB     = 3'd4,
    StWaitRdy  = 3'd5,
    StResp     = 3'd6
  } drv_state_e;

  function automatic logic [OPERAND_W:0] ref_sum(input logic [OPERAND_W-1:0] a,
                                                 input logic [OPERAND_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_op_driver_checker.sv
// Reference 5-bit sum of the latched operands compared against the adder's captured result.
module adder_op_driver_checker
  import adder_op_driver_pkg::*;
(
  input  logic [OPERAND_W-1:0] i_a,
  input  logic [OPERAND_W-1:0] i_b,
  input  logic [OPERAND_W-1:0] i_sum,
  input  logic                 i_carry,
  output logic                 o_mismatch
);

  assign o_mismatch = ({i_carry, i_sum} != ref_sum(i_a, i_b));

endmodule

// File: rtl/adder_op_driver.sv
// Initiator for the 4-bit adder pins: sequences load_a/load_b, captures and self-checks the
// result, and returns it on a valid/ready port. All outputs are registered.
module adder_op_driver
  import adder_op_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [OPERAND_W-1:0] op_a,
  input  logic [OPERAND_W-1:0] op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OPERAND_W-1:0] res_sum,
  output logic                 res_carry,
  output logic                 res_timeout,
  output logic                 res_mismatch,
  output logic [OPERAND_W-1:0] dut_data,
  output logic                 dut_load_a,
  output logic                 dut_load_b,
  input  logic [OPERAND_W-1:0] dut_sum,
  input  logic                 dut_carry,
  input  logic                 dut_ready,
  input  logic [1:0]           dut_state,
  output logic [7:0]           err_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  drv_state_e           r_state, w_state_d;
  logic [OPERAND_W-1:0] r_a, r_b, w_a_d, w_b_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic                 r_op_ready, r_res_valid, r_res_carry, r_res_timeout, r_res_mismatch;
  logic                 w_res_carry_d, w_res_timeout_d, w_res_mismatch_d;
  logic [OPERAND_W-1:0] r_res_sum, w_res_sum_d, r_dut_data, w_dut_data_d;
  logic                 r_dut_load_a, r_dut_load_b;
  logic [7:0]           r_err_count;
  logic                 w_accept, w_mismatch, w_err_inc;

  adder_op_driver_checker u_checker (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_sum     (dut_sum),
    .i_carry   (dut_carry),
    .o_mismatch(w_mismatch)
  );

  assign w_accept = op_valid && r_op_ready && (r_state == StIdle);

  always_comb begin
    w_state_d        = r_state;
    w_a_d            = r_a;
    w_b_d            = r_b;
    w_cnt_d          = r_cnt;
    w_res_sum_d      = r_res_sum;
    w_res_carry_d    = r_res_carry;
    w_res_timeout_d  = r_res_timeout;
    w_res_mismatch_d = r_res_mismatch;
    w_err_inc        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_a_d = op_a;
          w_b_d = op_b;
          // An adder left holding A would pair our A load with stale data; flush it first.
          w_state_d = (dut_state == AdderLoadedA) ? StFlushB : StDrvA;
        end
      end
      StFlushB:   w_state_d = StFlushGap;
      StFlushGap: w_state_d = StDrvA;
      StDrvA:     w_state_d = StDrvB;
      StDrvB: begin
        w_state_d = StWaitRdy;
        w_cnt_d   = '0;
      end
      StWaitRdy: begin
        if (dut_ready) begin
          w_res_sum_d      = dut_sum;
          w_res_carry_d    = dut_carry;
          w_res_timeout_d  = 1'b0;
          w_res_mismatch_d = w_mismatch;
          w_err_inc        = w_mismatch;
          w_state_d        = StResp;
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_res_sum_d      = '0;
          w_res_carry_d    = 1'b0;
          w_res_timeout_d  = 1'b1;
          w_res_mismatch_d = 1'b0;
          w_err_inc        = 1'b1;
          w_state_d        = StResp;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResp: begin
        if (res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_dut_data_d = r_dut_data;
    case (w_state_d)
      StFlushB, StFlushGap: w_dut_data_d = '0;
      StDrvA:               w_dut_data_d = w_a_d;
      StDrvB, StWaitRdy:    w_dut_data_d = w_b_d;
      default:              w_dut_data_d = r_dut_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_a            <= '0;
      r_b            <= '0;
      r_cnt          <= '0;
      r_op_ready     <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_sum      <= '0;
      r_res_carry    <= 1'b0;
      r_res_timeout  <= 1'b0;
      r_res_mismatch <= 1'b0;
      r_dut_data     <= '0;
      r_dut_load_a   <= 1'b0;
      r_dut_load_b   <= 1'b0;
      r_err_count    <= '0;
    end else if (ena) begin
      r_state        <= w_state_d;
      r_a            <= w_a_d;
      r_b            <= w_b_d;
      r_cnt          <= w_cnt_d;
      r_op_ready     <= (w_state_d == StIdle);
      r_res_valid    <= (w_state_d == StResp);
      r_res_sum      <= w_res_sum_d;
      r_res_carry    <= w_res_carry_d;
      r_res_timeout  <= w_res_timeout_d;
      r_res_mismatch <= w_res_mismatch_d;
      r_dut_data     <= w_dut_data_d;
      r_dut_load_a   <= (w_state_d == StDrvA);
      r_dut_load_b   <= (w_state_d == StFlushB) || (w_state_d == StDrvB);
      if (w_err_inc && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign op_ready     = r_op_ready;
  assign res_valid    = r_res_valid;
  assign res_sum      = r_res_sum;
  assign res_carry    = r_res_carry;
  assign res_timeout  = r_res_timeout;
  assign res_mismatch = r_res_mismatch;
  assign dut_data     = r_dut_data;
  assign dut_load_a   = r_dut_load_a;
  assign dut_load_b   = r_dut_load_b;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_adder_op_driver.sv
// Driver paired with a small behavioural 4-bit adder core; directed vectors plus corner sequences.
module tb_adder_op_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       op_valid = 1'b0, op_ready;
  logic [3:0] op_a = '0, op_b = '0;
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_sum;
  logic       res_carry, res_timeout, res_mismatch;
  logic [3:0] dut_data, dut_sum;
  logic       dut_load_a, dut_load_b, dut_carry, dut_ready;
  logic [1:0] dut_state;
  logic [7:0] err_count;

  // Adder core model and its hooks (manual drive, ready kill, sum corruption).
  logic       manual = 1'b0, m_load_a = 1'b0, m_load_b = 1'b0, kill_ready = 1'b0;
  logic [3:0] m_data = '0, flip = '0;
  logic [3:0] ad_a, ad_sum;
  logic       ad_carry;
  logic [1:0] ad_st;
  logic       w_ld_a, w_ld_b;
  logic [3:0] w_data;

  assign w_ld_a    = manual ? m_load_a : dut_load_a;
  assign w_ld_b    = manual ? m_load_b : dut_load_b;
  assign w_data    = manual ? m_data : dut_data;
  assign dut_state = ad_st;
  assign dut_ready = (ad_st == 2'b10) && !kill_ready;
  assign dut_sum   = ad_sum ^ flip;
  assign dut_carry = ad_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_st <= 2'b00; ad_a <= '0; ad_sum <= '0; ad_carry <= 1'b0;
    end else if (ena) begin
      if (w_ld_a) begin
        ad_a  <= w_data;
        ad_st <= 2'b01;
      end else if (w_ld_b && ad_st == 2'b01) begin
        {ad_carry, ad_sum} <= {1'b0, ad_a} + {1'b0, w_data};
        ad_st <= 2'b10;
      end
    end
  end

  adder_op_driver #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_carry(res_carry),
    .res_timeout(res_timeout), .res_mismatch(res_mismatch),
    .dut_data(dut_data), .dut_load_a(dut_load_a), .dut_load_b(dut_load_b),
    .dut_sum(dut_sum), .dut_carry(dut_carry), .dut_ready(dut_ready), .dut_state(dut_state),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ldb_pulses = 0, both_high = 0;

  always @(posedge clk) begin
    if (ena && dut_load_b) ldb_pulses++;
    if (dut_load_a && dut_load_b) both_high++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair and return once the accepting edge has passed.
  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    op_a = a; op_b = b; op_valid = 1'b1;
    while (!op_ready && n < 20) begin tick(); n++; end
    if (!op_ready) chk("op_ready_wait", 0, 1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 30) begin tick(); lat++; end
    if (!res_valid) chk("res_valid_wait", 0, 1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a, b, sum;
    logic       carry;
  } vec_t;

  vec_t vecs[6];
  int   lat, p0;
  logic ok;

  initial begin
    vecs[0] = '{a: 4'd3,  b: 4'd4,  sum: 4'd7,  carry: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  sum: 4'd0,  carry: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd15, sum: 4'd14, carry: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  sum: 4'd0,  carry: 1'b0};
    vecs[4] = '{a: 4'd9,  b: 4'd6,  sum: 4'd15, carry: 1'b0};
    vecs[5] = '{a: 4'd8,  b: 4'd8,  sum: 4'd0,  carry: 1'b1};

    // Reset, then one clock with ena low: op_ready must stay low.
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_op_ready", op_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_dut_bus", {dut_data, dut_load_a, dut_load_b}, 0);
    chk("reset_err_count", err_count, 0);
    ena = 1'b1;
    tick();
    chk("op_ready_after_ena", op_ready, 1);

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b);
      wait_res(lat);
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_sum", i), res_sum, vecs[i].sum);
      chk($sformatf("v%0d_carry", i), res_carry, vecs[i].carry);
      chk($sformatf("v%0d_flags", i), {res_timeout, res_mismatch}, 0);
      consume();
      chk($sformatf("v%0d_valid_drop", i), res_valid, 0);
    end
    chk("err_count_clean", err_count, 0);

    // Adder left in LOADED_A: driver must flush with an extra load_b first.
    manual = 1'b1; m_data = 4'd5; m_load_a = 1'b1;
    tick();
    m_load_a = 1'b0; manual = 1'b0;
    p0 = ldb_pulses;
    send(4'd2, 4'd2);
    wait_res(lat);
    chk("flush_latency", lat, 5);
    chk("flush_sum", {res_carry, res_sum}, 4);
    chk("flush_mismatch", res_mismatch, 0);
    consume();
    chk("flush_ldb_pulses", ldb_pulses - p0, 2);

    // Adder never ready: timeout after 8 cycles in WAIT_RDY.
    kill_ready = 1'b1;
    send(4'd1, 4'd2);
    wait_res(lat);
    chk("timeout_latency", lat, 10);
    chk("timeout_flag", res_timeout, 1);
    chk("timeout_result", {res_carry, res_sum, res_mismatch}, 0);
    chk("timeout_err_count", err_count, 1);
    consume();
    kill_ready = 1'b0;

    // Corrupted sum: mismatch flagged, fields held while consumer stalls.
    flip = 4'b0001;
    send(4'd3, 4'd4);
    wait_res(lat);
    flip = 4'b0000;
    chk("mismatch_flag", res_mismatch, 1);
    chk("mismatch_sum", res_sum, 6);
    chk("mismatch_err_count", err_count, 2);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!res_valid || res_sum != 4'd6 || !res_mismatch) ok = 1'b0;
    end
    chk("stall_stable", ok, 1);
    consume();

    // ena low for 3 cycles while load_b is on the pins.
    p0 = ldb_pulses;
    send(4'd5, 4'd6);
    tick();
    chk("drvb_load_b", dut_load_b, 1);
    ena = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!dut_load_b || dut_load_a || dut_data != 4'd6 || res_valid) ok = 1'b0;
    end
    chk("ena_hold", ok, 1);
    ena = 1'b1;
    wait_res(lat);
    chk("ena_latency", lat, 2);
    chk("ena_sum", {res_carry, res_sum}, 11);
    consume();
    chk("ena_ldb_pulses", ldb_pulses - p0, 1);

    // Reset during WAIT_RDY.
    kill_ready = 1'b1;
    send(4'd7, 4'd7);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_res", {res_valid, res_sum, res_carry, res_timeout, res_mismatch}, 0);
    chk("rst_dut_bus", {op_ready, dut_data, dut_load_a, dut_load_b}, 0);
    chk("rst_err_count", err_count, 0);
    kill_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(4'd1, 4'd1);
    wait_res(lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_sum", {res_carry, res_sum}, 2);
    consume();

    chk("loads_never_both", both_high, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
